can_bit_destuff: RTL and testbench

CAN_BIT_DESTUFF -- requirements
Module: can_bit_destuff

---
 rtl/can_pkg.sv | 33 +++
 rtl/can_rx_sync.sv | 35 +++
 rtl/can_bit_destuff.sv | 266 ++++++++++++++++++++++++++
 tb/tb_can_bit_destuff.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// can_pkg -- shared types and constants for the CAN bit destuffer.
// Holds the receiver state encoding, the bit-stuffing run limit and the
// bus-idle / end-of-frame recessive bit counts.
package can_pkg;

  // Receiver states: wait for bus idle, wait for SOF, inside a frame.
  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2
  } can_state_e;

  // Five equal bits in a row force a complementary stuff bit.
  localparam int STUFF_LIMIT   = 5;
  // Recessive bit times needed before the bus is considered idle.
  localparam int IDLE_BITS     = 11;
  // Recessive samples (outside the stuffed region) that end a frame.
  localparam int EOF_RECESSIVE = 10;

  localparam int RUN_W = 3;

  // Run-length increment that saturates at the stuffing limit.
  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] cnt);
    logic [RUN_W-1:0] res;
    if (cnt >= RUN_W'(STUFF_LIMIT)) begin
      res = RUN_W'(STUFF_LIMIT);
    end else begin
      res = cnt + RUN_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/can_rx_sync.sv
// can_rx_sync -- brings the asynchronous CAN line into the clk domain.
// Two flops resolve metastability, a third holds the previous synchronized
// value so a recessive-to-dominant (1->0) transition can be flagged.
// All flops reset to recessive so no false edge appears after reset.
module can_rx_sync
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_raw,
  output logic rx_s,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus edge-history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rx_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rx_s = r_sync;
  assign fall = r_prev & ~r_sync;

endmodule

// File: rtl/can_bit_destuff.sv
// can_bit_destuff -- CAN receive bit timing and destuffing.
// Synchronizes the line, waits for bus idle, hard-syncs on SOF, soft-resyncs
// on later falling edges, samples once per bit and strips stuff bits while
// the downstream stage reports the stuffed region.
// Optional feature macro: CAN_STUFF_ERR_EN -- when defined, a stuff violation
// pulses stuff_err and aborts the frame; otherwise stuff_err is tied low and
// the offending bit is dropped silently.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int BIT_CLKS   = 16,
  parameter int SAMPLE_CLK = 11,
  parameter int SJW_CLKS   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_raw,
  input  logic stuff_en,
  output logic bit_valid,
  output logic bit_val,
  output logic sof,
  output logic frame_active,
  output logic stuff_err
);

  localparam int PH_W     = $clog2(BIT_CLKS);
  localparam int INT_CLKS = IDLE_BITS * BIT_CLKS;
  localparam int INT_W    = $clog2(INT_CLKS + 1);
  localparam int EOF_W    = 4;

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_CLKS - 1);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(SAMPLE_CLK);
  localparam logic [PH_W-1:0]  PH_SJW    = PH_W'(SJW_CLKS);
  localparam logic [INT_W-1:0] INT_LAST  = INT_W'(INT_CLKS - 1);
  localparam logic [EOF_W-1:0] EOF_LAST  = EOF_W'(EOF_RECESSIVE - 1);

  // Synchronized line and falling-edge flag.
  logic w_rx_s;
  logic w_fall;

  can_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_raw (rx_raw),
    .rx_s   (w_rx_s),
    .fall   (w_fall)
  );

  // State and counters.
  can_state_e       r_state,        w_state_next;
  logic [PH_W-1:0]  r_phase,        w_phase_next;
  logic [INT_W-1:0] r_int_cnt,      w_int_cnt_next;
  logic [RUN_W-1:0] r_run_cnt,      w_run_cnt_next;
  logic             r_run_val,      w_run_val_next;
  logic [EOF_W-1:0] r_eof_cnt,      w_eof_cnt_next;
  logic             r_first,        w_first_next;
  logic             r_resynced,     w_resynced_next;
  logic             r_last_smp,     w_last_smp_next;

  // Registered outputs.
  logic r_bit_valid,    w_bit_valid_next;
  logic r_bit_val,      w_bit_val_next;
  logic r_sof,          w_sof_next;
  logic r_frame_active, w_frame_active_next;
  logic r_stuff_err,    w_stuff_err_next;

  // Decoded timing events inside a frame.
  logic w_sample_pt;
  logic w_resync_ok;

  assign w_sample_pt = (r_phase == PH_SAMPLE);

  // Soft resync only for a 1->0 edge away from the bit start and the sample
  // point, once between samples, and only when the last bit was recessive
  // (an edge after a dominant sample cannot be a genuine bit boundary).
  assign w_resync_ok = w_fall && (r_phase != '0) && (r_phase != PH_SAMPLE) &&
                       !r_resynced && r_last_smp;

  // Next-state, counter and output decode.
  always_comb begin
    w_state_next        = r_state;
    w_phase_next        = r_phase;
    w_int_cnt_next      = r_int_cnt;
    w_run_cnt_next      = r_run_cnt;
    w_run_val_next      = r_run_val;
    w_eof_cnt_next      = r_eof_cnt;
    w_first_next        = r_first;
    w_resynced_next     = r_resynced;
    w_last_smp_next     = r_last_smp;
    w_bit_valid_next    = 1'b0;
    w_bit_val_next      = 1'b0;
    w_sof_next          = 1'b0;
    w_frame_active_next = r_frame_active;
    w_stuff_err_next    = 1'b0;

    unique case (r_state)
      INTEGRATE: begin
        w_frame_active_next = 1'b0;
        if (w_rx_s) begin
          if (r_int_cnt == INT_LAST) begin
            w_state_next   = IDLE;
            w_int_cnt_next = '0;
          end else begin
            w_int_cnt_next = r_int_cnt + INT_W'(1);
          end
        end else begin
          w_int_cnt_next = '0;
        end
      end

      IDLE: begin
        w_frame_active_next = 1'b0;
        // Hard sync: the SOF edge defines phase 0 and opens a dominant run.
        if (w_fall) begin
          w_state_next    = FRAME;
          w_phase_next    = '0;
          w_run_cnt_next  = RUN_W'(1);
          w_run_val_next  = 1'b0;
          w_eof_cnt_next  = '0;
          w_first_next    = 1'b1;
          w_resynced_next = 1'b0;
          w_last_smp_next = 1'b0;
        end
      end

      FRAME: begin
        // Free-running bit phase.
        if (r_phase == PH_LAST) begin
          w_phase_next = '0;
        end else begin
          w_phase_next = r_phase + PH_W'(1);
        end

        // Phase correction limited to SJW, in either direction.
        if (w_resync_ok) begin
          w_resynced_next = 1'b1;
          if (r_phase < PH_SAMPLE) begin
            // Edge arrived late: pull the phase back.
            w_phase_next = (r_phase > PH_SJW) ? (r_phase - PH_SJW) : '0;
          end else if ((PH_LAST - r_phase) < PH_SJW) begin
            // Edge slightly early and within reach: start the new bit now.
            w_phase_next = '0;
          end else begin
            // Edge early beyond SJW: advance by the maximum allowed.
            w_phase_next = r_phase + PH_SJW;
          end
        end

        if (w_sample_pt) begin
          w_resynced_next = 1'b0;
          w_last_smp_next = w_rx_s;

          if (r_first) begin
            // SOF: the run was already opened at hard sync.
            w_first_next        = 1'b0;
            w_bit_valid_next    = 1'b1;
            w_bit_val_next      = 1'b0;
            w_sof_next          = 1'b1;
            w_frame_active_next = 1'b1;
          end else if (stuff_en) begin
            w_eof_cnt_next = '0;
            if (r_run_cnt == RUN_W'(STUFF_LIMIT)) begin
              if (w_rx_s != r_run_val) begin
                // Genuine stuff bit: swallow it, it opens a new run.
                w_run_cnt_next = RUN_W'(1);
                w_run_val_next = w_rx_s;
              end else begin
`ifdef CAN_STUFF_ERR_EN
                // Sixth equal bit: abort and re-integrate. This path wins
                // over any end-of-frame handling below.
                w_stuff_err_next    = 1'b1;
                w_state_next        = INTEGRATE;
                w_int_cnt_next      = '0;
                w_frame_active_next = 1'b0;
`else
                // Sixth equal bit tolerated: drop it and restart the run.
                w_run_cnt_next = RUN_W'(1);
`endif
              end
            end else begin
              w_bit_valid_next = 1'b1;
              w_bit_val_next   = w_rx_s;
              if (w_rx_s == r_run_val) begin
                w_run_cnt_next = run_inc(r_run_cnt);
              end else begin
                w_run_cnt_next = RUN_W'(1);
                w_run_val_next = w_rx_s;
              end
            end
          end else begin
            // Unstuffed region: every bit passes; the run is cleared so the
            // first stuffed bit afterwards begins counting from scratch.
            w_bit_valid_next = 1'b1;
            w_bit_val_next   = w_rx_s;
            w_run_cnt_next   = '0;
            w_run_val_next   = w_rx_s;
            if (w_rx_s) begin
              if (r_eof_cnt == EOF_LAST) begin
                w_state_next        = IDLE;
                w_eof_cnt_next      = '0;
                w_frame_active_next = 1'b0;
              end else begin
                w_eof_cnt_next = r_eof_cnt + EOF_W'(1);
              end
            end else begin
              w_eof_cnt_next = '0;
            end
          end
        end
      end

      default: begin
        w_state_next = INTEGRATE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= INTEGRATE;
      r_phase        <= '0;
      r_int_cnt      <= '0;
      r_run_cnt      <= '0;
      r_run_val      <= 1'b0;
      r_eof_cnt      <= '0;
      r_first        <= 1'b0;
      r_resynced     <= 1'b0;
      r_last_smp     <= 1'b0;
      r_bit_valid    <= 1'b0;
      r_bit_val      <= 1'b0;
      r_sof          <= 1'b0;
      r_frame_active <= 1'b0;
      r_stuff_err    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_phase        <= w_phase_next;
      r_int_cnt      <= w_int_cnt_next;
      r_run_cnt      <= w_run_cnt_next;
      r_run_val      <= w_run_val_next;
      r_eof_cnt      <= w_eof_cnt_next;
      r_first        <= w_first_next;
      r_resynced     <= w_resynced_next;
      r_last_smp     <= w_last_smp_next;
      r_bit_valid    <= w_bit_valid_next;
      r_bit_val      <= w_bit_val_next;
      r_sof          <= w_sof_next;
      r_frame_active <= w_frame_active_next;
      r_stuff_err    <= w_stuff_err_next;
    end
  end

  assign bit_valid    = r_bit_valid;
  assign bit_val      = r_bit_val;
  assign sof          = r_sof;
  assign frame_active = r_frame_active;
`ifdef CAN_STUFF_ERR_EN
  assign stuff_err    = r_stuff_err;
`else
  assign stuff_err    = 1'b0;
  // The error register is constant zero in this build.
  logic w_unused_err;
  assign w_unused_err = r_stuff_err;
`endif

endmodule

// File: tb/tb_can_bit_destuff.sv
// tb_can_bit_destuff -- directed bench for can_bit_destuff (default timing:
// 16 clk per bit, sample at phase 11, SJW 2). Expectations follow the build's
// CAN_STUFF_ERR_EN setting.
module tb_can_bit_destuff;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic rx_raw   = 1'b1;
  logic stuff_en = 1'b0;
  logic bit_valid;
  logic bit_val;
  logic sof;
  logic frame_active;
  logic stuff_err;

`ifdef CAN_STUFF_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  int cyc     = 0;
  int n_sof   = 0;
  int n_err   = 0;
  int sof_cyc = 0;
  bit bv_q[$];
  bit fa_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  can_bit_destuff #(
    .BIT_CLKS   (16),
    .SAMPLE_CLK (11),
    .SJW_CLKS   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_raw       (rx_raw),
    .stuff_en     (stuff_en),
    .bit_valid    (bit_valid),
    .bit_val      (bit_val),
    .sof          (sof),
    .frame_active (frame_active),
    .stuff_err    (stuff_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes half a cycle after the edge that produced them.
  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      bv_q.push_back(bit_val);
      fa_q.push_back(frame_active);
    end
    if (sof === 1'b1) begin
      n_sof   = n_sof + 1;
      sof_cyc = cyc;
    end
    if (stuff_err === 1'b1) n_err = n_err + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int per);
    rx_raw = b;
    wait_clk(per);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Out-of-range reads return 9 so they can never match a bit.
  function automatic int qv(input int i);
    if (i >= 0 && i < bv_q.size()) return int'(bv_q[i]);
    return 9;
  endfunction

  function automatic int qf(input int i);
    if (i >= 0 && i < fa_q.size()) return int'(fa_q[i]);
    return 9;
  endfunction

  initial begin
    int b0, s0, e0, t0, exp_v;

    // Reset state, during and right after reset.
    rst = 1'b1;
    wait_clk(3);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_sof", sof, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_stuff_err", stuff_err, 0);
    rst = 1'b0;
    wait_clk(1);
    check("post_rst_bit_valid", bit_valid, 0);
    check("post_rst_frame_active", frame_active, 0);
    wait_clk(180);

    // Frame A: SOF latency, stuffed stream 0,0,0,0,0,[1],1, then EOF.
    b0 = bv_q.size(); s0 = n_sof; e0 = n_err;
    stuff_en = 1'b1;
    rx_raw = 1'b0;
    t0 = cyc;
    wait_clk(16);
    check("A_sof_count", n_sof - s0, 1);
    check("A_sof_latency", sof_cyc - t0, 15);
    check("A_sof_val", qv(b0), 0);
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 16);
    check("A_stuffed_count", bv_q.size() - b0, 6);
    stuff_en = 1'b0;
    send_bit(1'b1, 16 * 13);
    check("A_total_count", bv_q.size() - b0, 16);
    for (int i = 0; i < 16; i++) begin
      exp_v = (i >= 5) ? 1 : 0;
      check($sformatf("A_bit%0d", i), qv(b0 + i), exp_v);
    end
    check("A_fa_before_last", qf(b0 + 14), 1);
    check("A_fa_at_last", qf(b0 + 15), 0);
    check("A_fa_idle", frame_active, 0);
    check("A_no_err", n_err - e0, 0);

    // Frame B: new SOF 3 bits after EOF, then six dominant bits.
    b0 = bv_q.size(); s0 = n_sof; e0 = n_err;
    stuff_en = 1'b1;
    rx_raw = 1'b0;
    t0 = cyc;
    wait_clk(16);
    check("B_sof_count", n_sof - s0, 1);
    check("B_sof_latency", sof_cyc - t0, 15);
    send_bit(1'b0, 16 * 5);
    check("B_bits_before_6th", bv_q.size() - b0, 5);
    check("B_stuff_err_count", n_err - e0, ERR_EN);
    check("B_frame_active", frame_active, (ERR_EN == 1) ? 0 : 1);
    stuff_en = 1'b0;
    send_bit(1'b1, 16 * 14);
    check("B_idle_frame_active", frame_active, 0);

    // Frame C: transmitter bit period 17, 64 alternating bits after SOF.
    b0 = bv_q.size(); s0 = n_sof; e0 = n_err;
    stuff_en = 1'b1;
    rx_raw = 1'b0;
    t0 = cyc;
    wait_clk(17);
    check("C_sof_latency", sof_cyc - t0, 15);
    for (int i = 1; i <= 64; i++) begin
      send_bit((i % 2) == 1, 17);
    end
    stuff_en = 1'b0;
    send_bit(1'b1, 16 * 14);
    check("C_total_count", bv_q.size() - b0, 75);
    for (int i = 0; i < 75; i++) begin
      exp_v = (i <= 64) ? (i % 2) : 1;
      check($sformatf("C_bit%0d", i), qv(b0 + i), exp_v);
    end
    check("C_sof_count", n_sof - s0, 1);
    check("C_no_err", n_err - e0, 0);

    // Frame D: reset after the 20th decoded bit.
    b0 = bv_q.size();
    stuff_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bv_q.size() - b0 >= 20) break;
      send_bit((k % 2) == 1, 16);
    end
    check("D_bits_before_rst", bv_q.size() - b0, 20);
    rst = 1'b1;
    rx_raw = 1'b1;
    stuff_en = 1'b0;
    b0 = bv_q.size(); s0 = n_sof; e0 = n_err;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(150);
    send_bit(1'b0, 20);
    send_bit(1'b1, 175);
    send_bit(1'b0, 20);
    check("D_no_bits_after_rst", bv_q.size() - b0, 0);
    check("D_no_sof_after_rst", n_sof - s0, 0);
    check("D_no_err_after_rst", n_err - e0, 0);
    check("D_fa_after_rst", frame_active, 0);
    send_bit(1'b1, 176);
    rx_raw = 1'b0;
    t0 = cyc;
    wait_clk(16);
    check("D_sof_after_176", n_sof - s0, 1);
    check("D_sof_latency", sof_cyc - t0, 15);
    rx_raw = 1'b1;
    wait_clk(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
